// File: rtl/orch85_audio_dac_if.sv
`default_nettype none
// ============================================================================
//  Module      : orch85_audio_dac_if
//  Description : Write bus from the TRS-IO port decoder into the sound stage.
//                The decoder drives one-clock strobes with their data; the
//                DAC only listens.
//  Revision    : 1.0 - initial release
// ============================================================================
interface orch85_audio_dac_if;
  logic       orch_l_we;
  logic       orch_r_we;
  logic [7:0] orch_d;
  logic       cass_we;
  logic [1:0] cass_d;

  modport master (
    output orch_l_we, orch_r_we, orch_d, cass_we, cass_d
  );

  modport slave (
    input orch_l_we, orch_r_we, orch_d, cass_we, cass_d
  );
endinterface
`default_nettype wire

// File: rtl/orch85_audio_dac.sv
`default_nettype none
// ============================================================================
//  Module      : orch85_audio_dac
//  Description : Orchestra-85 stereo sound stage. Latches left/right sample
//                writes and the cassette output level, mixes them once per
//                sample tick, and drives a first-order delta-sigma bitstream
//                per channel. Mutes itself when the Z80 stops writing.
//  Config      : define AUDIO_RAMP_EN to slew-limit the mixed value by
//                RAMP_STEP per tick (click-free mute entry/exit).
//  Revision    : 1.0 - initial release
// ============================================================================
module orch85_audio_dac #(
  parameter int SAMPLE_DIV = 2272,
  parameter int IDLE_TICKS = 4096,
  parameter int CASS_AMPL  = 64,
  parameter int RAMP_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  orch85_audio_dac_if.slave bus,
  output logic              dac_left,
  output logic              dac_right,
  output logic              tick,
  output logic              muted
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [7:0]        CASS_POS  = 8'(CASS_AMPL);
  localparam logic [7:0]        CASS_NEG  = 8'(-CASS_AMPL);

`ifdef AUDIO_RAMP_EN
  localparam int STEP_LIM = RAMP_STEP;
`else
  // A limit above 255 can never bind, so the mix follows the target directly.
  localparam int STEP_LIM = RAMP_STEP | 256;
`endif
  localparam logic signed [9:0] STEP = 10'(STEP_LIM);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              muted_q, muted_d;
  logic [7:0]        cass_lvl_q, cass_lvl_d;
  logic              any_we;
  logic [1:0]        cv;

  logic [7:0] hold_q [2];
  logic [7:0] mix_q  [2];
  logic [7:0] acc_q  [2];
  logic       dac_q  [2];

  assign tick  = (tick_cnt_q == TICK_LAST);
  assign muted = muted_q;

  // Shared next-state: sample-rate divider, idle/mute tracking, cassette level.
  always_comb begin
    any_we     = bus.orch_l_we | bus.orch_r_we | bus.cass_we;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;

    // A write always restarts the idle window, even on a tick cycle.
    idle_d = idle_q;
    if (any_we) begin
      idle_d = '0;
    end else if (tick && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + IDLE_ONE;
    end
    // Mute decision uses the post-edge idle count so silence lands on the same tick.
    muted_d = (idle_d == IDLE_MAX);

    // Bit 1 of the cassette port is inverted on the real hardware.
    cv         = {~bus.cass_d[1], bus.cass_d[0]};
    cass_lvl_d = cass_lvl_q;
    if (bus.cass_we) begin
      case (cv)
        2'b00:   cass_lvl_d = CASS_NEG;
        2'b11:   cass_lvl_d = CASS_POS;
        default: cass_lvl_d = 8'h00;
      endcase
    end
  end

  // Shared state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      idle_q     <= IDLE_MAX;
      muted_q    <= 1'b1;
      cass_lvl_q <= 8'h00;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idle_q     <= idle_d;
      muted_q    <= muted_d;
      cass_lvl_q <= cass_lvl_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic              we;
    logic [7:0]        hold_d, mix_d, acc_d, u, t_sat, t;
    logic signed [8:0] sum;
    logic signed [9:0] mix_x, diff, stepped;
    logic              carry;

    assign we = (ch == 0) ? bus.orch_l_we : bus.orch_r_we;

    // Channel datapath: sample latch, saturating mix, slew limit, modulator.
    always_comb begin
      hold_d = we ? bus.orch_d : hold_q[ch];

      sum = {hold_q[ch][7], hold_q[ch]} + {cass_lvl_q[7], cass_lvl_q};
      if (sum > 9'sd127) begin
        t_sat = 8'h7F;
      end else if (sum < -9'sd128) begin
        t_sat = 8'h80;
      end else begin
        t_sat = sum[7:0];
      end
      t = muted_d ? 8'h00 : t_sat;

      mix_x = {{2{mix_q[ch][7]}}, mix_q[ch]};
      diff  = {{2{t[7]}}, t} - mix_x;
      if (diff > STEP) begin
        stepped = mix_x + STEP;
      end else if (diff < -STEP) begin
        stepped = mix_x - STEP;
      end else begin
        stepped = {{2{t[7]}}, t};
      end
      mix_d = tick ? stepped[7:0] : mix_q[ch];

      // Offset-binary input; the accumulator carry is the output bit.
      u              = mix_q[ch] ^ 8'h80;
      {carry, acc_d} = {1'b0, acc_q[ch]} + {1'b0, u};
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q[ch] <= 8'h00;
        mix_q[ch]  <= 8'h00;
        acc_q[ch]  <= 8'h00;
        dac_q[ch]  <= 1'b0;
      end else begin
        hold_q[ch] <= hold_d;
        mix_q[ch]  <= mix_d;
        acc_q[ch]  <= acc_d;
        dac_q[ch]  <= carry;
      end
    end
  end

  assign dac_left  = dac_q[0];
  assign dac_right = dac_q[1];

endmodule
`default_nettype wire
